// File: rtl/change_dispenser.sv
// Greedy change payout: ejects quarters, dimes and nickels as timed pulses,
// then reports per-coin counts and any sub-nickel remainder.
module change_dispenser #(
  parameter int PULSE_CYCLES = 5_000_000,
  parameter int GAP_CYCLES   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] change_in,
  output logic       busy,
  output logic       done,
  output logic       coin_q,
  output logic       coin_d,
  output logic       coin_n,
  output logic [3:0] q_count,
  output logic [1:0] d_count,
  output logic       n_count,
  output logic [2:0] leftover,
  output logic       err_rem
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PICK, PULSE, GAP, DONE} state_e;
  typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_e;

  state_e        state_q;
  coin_e         sel_q;
  coin_e         pick_d;
  logic [7:0]    rem_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    eject_q;
  logic          busy_q;
  logic          done_q;
  logic [3:0]    q_cnt_q;
  logic [1:0]    d_cnt_q;
  logic          n_cnt_q;
  logic [2:0]    leftover_q;
  logic          err_q;

  function automatic coin_e pick_coin(input logic [7:0] rem);
    if (rem >= 8'd25)      return COIN_Q;
    else if (rem >= 8'd10) return COIN_D;
    else if (rem >= 8'd5)  return COIN_N;
    else                   return COIN_NONE;
  endfunction

  function automatic logic [7:0] coin_value(input coin_e c);
    case (c)
      COIN_Q:  return 8'd25;
      COIN_D:  return 8'd10;
      COIN_N:  return 8'd5;
      default: return 8'd0;
    endcase
  endfunction

  // One-hot eject vector ordered {quarter, dime, nickel}.
  function automatic logic [2:0] coin_eject(input coin_e c);
    case (c)
      COIN_Q:  return 3'b100;
      COIN_D:  return 3'b010;
      COIN_N:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    pick_d = pick_coin(rem_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= COIN_NONE;
      rem_q      <= '0;
      timer_q    <= '0;
      eject_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_cnt_q    <= '0;
      d_cnt_q    <= '0;
      n_cnt_q    <= 1'b0;
      leftover_q <= '0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q      <= change_in;
            q_cnt_q    <= '0;
            d_cnt_q    <= '0;
            n_cnt_q    <= 1'b0;
            leftover_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= PICK;
          end
        end
        PICK: begin
          if (pick_d == COIN_NONE) begin
            done_q     <= 1'b1;
            leftover_q <= rem_q[2:0];
            err_q      <= (rem_q != 8'd0);
            state_q    <= DONE;
          end else begin
            sel_q   <= pick_d;
            eject_q <= coin_eject(pick_d);
            timer_q <= PULSE_LOAD;
            state_q <= PULSE;
          end
        end
        PULSE: begin
          // Coin is accounted for only once its pulse has fully elapsed.
          if (timer_q == '0) begin
            eject_q <= '0;
            rem_q   <= rem_q - coin_value(sel_q);
            case (sel_q)
              COIN_Q:  q_cnt_q <= q_cnt_q + 4'd1;
              COIN_D:  d_cnt_q <= d_cnt_q + 2'd1;
              COIN_N:  n_cnt_q <= n_cnt_q + 1'b1;
              default: ;
            endcase
            timer_q <= GAP_LOAD;
            state_q <= GAP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        GAP: begin
          if (timer_q == '0) state_q <= PICK;
          else               timer_q <= timer_q - 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy                     = busy_q;
  assign done                     = done_q;
  assign {coin_q, coin_d, coin_n} = eject_q;
  assign q_count                  = q_cnt_q;
  assign d_count                  = d_cnt_q;
  assign n_count                  = n_cnt_q;
  assign leftover                 = leftover_q;
  assign err_rem                  = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser with short pulse/gap timing.
module tb_change_dispenser;
  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] change_in;
  logic       busy, done, coin_q, coin_d, coin_n, n_count, err_rem;
  logic [3:0] q_count;
  logic [1:0] d_count;
  logic [2:0] leftover;

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in),
    .busy(busy), .done(done), .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
    .q_count(q_count), .d_count(d_count), .n_count(n_count),
    .leftover(leftover), .err_rem(err_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q, d, n, lo, err, done_cyc;
  } res_t;

  res_t       res_q[$];
  logic [2:0] exp_coins[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         last_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Greedy reference: queue the coin order and the final report.
  task automatic expect_payout(input int v, input int e);
    res_t r;
    int rem = v;
    r.q = 0; r.d = 0; r.n = 0;
    while (rem >= 25) begin exp_coins.push_back(3'b100); rem -= 25; r.q++; end
    while (rem >= 10) begin exp_coins.push_back(3'b010); rem -= 10; r.d++; end
    while (rem >= 5)  begin exp_coins.push_back(3'b001); rem -= 5;  r.n++; end
    r.lo = rem;
    r.err = (rem != 0) ? 1 : 0;
    r.done_cyc = e + 1 + (r.q + r.d + r.n) * (P + G + 1);
    res_q.push_back(r);
  endtask

  task automatic go(input int v, input bit track);
    @(negedge clk);
    start = 1'b1;
    change_in = 8'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    last_e = cyc;
    if (track) expect_payout(v, cyc);
  endtask

  task automatic wait_done();
    int c0 = done_cnt;
    int i = 0;
    while (done_cnt == c0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("done_timeout", (done_cnt != c0) ? 1 : 0, 1);
  endtask

  logic [2:0] prev_ej = '0;
  int         plen = 0;
  int         lowlen = 0;
  bit         seen_fall = 1'b0;

  always @(negedge clk) begin
    logic [2:0] ej;
    logic [2:0] e;
    res_t r;
    ej = {coin_q, coin_d, coin_n};
    if (!rst) begin
      prev_ej = '0; plen = 0; lowlen = 0; seen_fall = 1'b0;
    end else begin
      chk("coin_onehot", $onehot0(ej) ? 1 : 0, 1);
      if (ej != 3'b000 && prev_ej == 3'b000) begin
        if (exp_coins.size() == 0) chk("unexpected_coin", ej, 0);
        else begin
          e = exp_coins.pop_front();
          chk("coin_kind", ej, e);
        end
        if (seen_fall) chk("gap_len", lowlen, G + 1);
        plen = 1;
      end else if (ej != 3'b000) begin
        chk("coin_stable", ej, prev_ej);
        plen++;
      end else if (prev_ej != 3'b000) begin
        chk("pulse_len", plen, P);
        lowlen = 1;
        seen_fall = 1'b1;
      end else begin
        lowlen++;
      end
      if (done) begin
        done_cnt++;
        seen_fall = 1'b0;
        if (res_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("done_cycle", cyc, r.done_cyc);
          chk("q_count", q_count, r.q);
          chk("d_count", d_count, r.d);
          chk("n_count", n_count, r.n);
          chk("leftover", leftover, r.lo);
          chk("err_rem", err_rem, r.err);
          chk("busy_at_done", busy, 1);
          chk("coins_pending", exp_coins.size(), 0);
        end
      end
      prev_ej = ej;
    end
  end

  initial begin
    int dc;
    rst = 1'b0;
    start = 1'b0;
    change_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coins", {coin_q, coin_d, coin_n}, 0);
    chk("rst_counts", {q_count, d_count, n_count}, 0);
    chk("rst_report", {leftover, err_rem}, 0);
    rst = 1'b1;

    go(15, 1'b1);
    wait_done();

    go(0, 1'b1);
    @(negedge clk);
    chk("zero_busy_k1", busy, 1);
    chk("zero_done_k1", done, 0);
    @(negedge clk);
    chk("zero_busy_k2", busy, 1);
    chk("zero_done_k2", done, 1);
    @(negedge clk);
    chk("zero_busy_k3", busy, 0);

    go(65, 1'b1);
    wait_done();

    go(255, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);
    chk("hold_q_count", q_count, 10);
    chk("hold_n_count", n_count, 1);

    go(7, 1'b1);
    wait_done();
    repeat (4) @(negedge clk);
    chk("hold_leftover", leftover, 2);
    chk("hold_err_rem", err_rem, 1);

    go(50, 1'b1);
    for (int i = 0; i < 50 && !coin_q; i++) @(negedge clk);
    chk("first_quarter_seen", coin_q, 1);
    go(25, 1'b0);
    wait_done();

    go(40, 1'b0);
    exp_coins.push_back(3'b100);
    exp_coins.push_back(3'b010);
    for (int i = 0; i < 50 && !coin_d; i++) @(negedge clk);
    chk("second_pulse_seen", coin_d, 1);
    dc = done_cnt;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_coins", {coin_q, coin_d, coin_n}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_counts", {q_count, d_count, n_count}, 0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, dc);
    chk("arst_coins_consumed", exp_coins.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    go(10, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("results_pending", res_q.size(), 0);
    chk("coins_remaining", exp_coins.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
